des_batch_scheduler: RTL
========================

# des_batch_scheduler

Controller that sequences the pipelined DES encryption core for a batch of chosen-plaintext encryptions. On `start` it issues `num_msgs` plaintexts, one per cycle, from a 64-bit LFSR into the core. A second, identical LFSR regenerates each plaintext when its ciphertext returns, so no delay line is needed, and each result leaves as a plaintext/ciphertext pair. It sits between the top-level block FSM and the pipelined DES core; round keys go straight to the core and are outside this block.

## Interface

Parameters:
- `CNT_W`, 32: width of the message counters and of `num_msgs`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  batch request; acted on only in IDLE or FINISHED.
- `num_msgs`  in  CNT_W  batch size; sampled when `start` is accepted.
- `seed`  in  64  LFSR seed; sampled when `start` is accepted.
- `des_start`  out  1  message valid to the DES core; one message per high cycle.
- `des_message`  out  64  plaintext to the DES core.
- `des_output_valid`  in  1  ciphertext valid from the core.
- `des_result`  in  64  ciphertext from the core.
- `pair_valid`  out  1  one-cycle strobe; a pair is present.
- `pair_plaintext`  out  64  regenerated plaintext.
- `pair_ciphertext`  out  64  registered `des_result`.
- `busy`  out  1  high in ISSUE and DRAIN.
- `done`  out  1  high while in FINISHED.
- `err`  out  1  sticky; an unexpected `des_output_valid` occurred.

## Operation

- States: IDLE, ISSUE, DRAIN, FINISHED.
- Reset: state goes to IDLE. All outputs are 0. Both LFSRs, both counters and `err` are cleared.
- LFSR step, used by both LFSRs:
  - next = {s[62:0], s[63]^s[62]^s[60]^s[59]}.
  - A zero seed is replaced by 64'h1.
- Accepting `start` in IDLE or FINISHED:
  - Latch `num_msgs`.
  - Load the issue LFSR and the check LFSR with the seed.
  - Clear issued/received counts and `err`.
  - Go to ISSUE; if `num_msgs`==0, go to FINISHED instead.
  - `start` in ISSUE or DRAIN is ignored.
- ISSUE, every cycle:
  - `des_start`=1 and `des_message`=issue LFSR value.
  - Advance the issue LFSR and increment the issued count.
  - When the issued count reaches `num_msgs`, go to DRAIN on the following cycle.
  - No stalls: the core accepts one message per cycle.
- `des_output_valid` in ISSUE or DRAIN with received < `num_msgs`:
  - Register `pair_ciphertext`=`des_result` and `pair_plaintext`=check LFSR value.
  - Pulse `pair_valid`, advance the check LFSR, increment the received count.
- Leaving DRAIN: on the cycle the final result is captured (received becomes `num_msgs`), the next state is FINISHED.
- `des_output_valid` when not expected (IDLE, FINISHED, or received == `num_msgs`): no pair is produced, and `err` is set to 1 and held until the next accepted `start` or reset.
- Counter arithmetic: unsigned, CNT_W bits, no wrap. `num_msgs` up to 2^CNT_W−1.

## Timing

- `start` accepted at edge T: `des_start` is high from T+1 through T+N, where N = `num_msgs`.
- Message k (k = 0..N−1) is presented at T+1+k and equals seed advanced k times.
- Result arriving at edge R: `pair_valid` is high during cycle R+1.
- Core latency L: last result at T+N+L; `pair_valid` ends at T+N+L+1.
- `done` rises in the same cycle as the last `pair_valid` and stays high until the next accepted `start` or reset.
- `busy` is high from T+1 until `done` rises.
- `des_start` and `pair_valid` are registered outputs; neither drives combinationally from inputs.
- `start` and `des_output_valid` on the same edge in FINISHED:
  - The restart wins.
  - The stray valid is ignored, and `err` is cleared by the restart.
- Reset mid-batch: IDLE on the next cycle, all outputs 0. The DES core shares `rst_n` and is flushed with it.

## Test plan

- Seed 64'h1, N=4, core model with L=17:
  - `des_message` = 1, 2, 4, 8 on four consecutive cycles.
  - Four `pair_valid` strobes, with the plaintexts in the same order.
  - `done` high at T+22; `err`=0.
- N=0: `start` leads to FINISHED on the next cycle. `des_start` never goes high; `done`=1 one cycle after `start`.
- Seed 0: the first message is 64'h1, identical to the seed-1 run.
- Core model injects an extra `des_output_valid` after the Nth result:
  - `err`=1 and stays 1.
  - No fifth `pair_valid`.
  - `done` unaffected.
- Reset asserted at the midpoint of ISSUE with N=100:
  - Next cycle: IDLE, `busy`=0, `des_start`=0.
  - A subsequent `start` with N=3 produces exactly three pairs.
- `start` pulsed during DRAIN:
  - Ignored; the batch completes with N pairs.
  - A `start` in FINISHED begins a new batch; `done` drops at T+1.

Source files
------------

// File: rtl/des_batch_scheduler.sv
// rtl/des_batch_scheduler.sv - Feeds LFSR plaintexts to a pipelined DES core
// and pairs each returning ciphertext with a regenerated plaintext.
module des_batch_scheduler #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_msgs,
  input  logic [63:0]      i_seed,
  output logic             o_des_start,
  output logic [63:0]      o_des_message,
  input  logic             i_des_output_valid,
  input  logic [63:0]      i_des_result,
  output logic             o_pair_valid,
  output logic [63:0]      o_pair_plaintext,
  output logic [63:0]      o_pair_ciphertext,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FINISHED
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_received;
  logic [63:0]      r_issue_lfsr;
  logic [63:0]      r_check_lfsr;

  logic [63:0]      w_seed;
  logic             w_active;
  logic             w_rx_ok;
  logic             w_rx_last;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  // An all-zero state would lock the LFSR, so it is never loaded.
  assign w_seed    = (i_seed == 64'd0) ? 64'd1 : i_seed;
  assign w_active  = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_rx_ok   = w_active && i_des_output_valid && (r_received != r_num);
  assign w_rx_last = w_rx_ok && ((r_received + CNT_W'(1)) == r_num);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state           <= S_IDLE;
      r_num             <= '0;
      r_issued          <= '0;
      r_received        <= '0;
      r_issue_lfsr      <= '0;
      r_check_lfsr      <= '0;
      o_des_start       <= 1'b0;
      o_des_message     <= '0;
      o_pair_valid      <= 1'b0;
      o_pair_plaintext  <= '0;
      o_pair_ciphertext <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_err             <= 1'b0;
    end else begin
      o_pair_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_FINISHED: begin
          if (i_start) begin
            r_num        <= i_num_msgs;
            r_received   <= '0;
            r_check_lfsr <= w_seed;
            o_err        <= 1'b0;
            if (i_num_msgs == '0) begin
              r_state      <= S_FINISHED;
              r_issued     <= '0;
              r_issue_lfsr <= w_seed;
              o_des_start  <= 1'b0;
              o_busy       <= 1'b0;
              o_done       <= 1'b1;
            end else begin
              // The first message is launched on the accepting edge so that
              // des_start is a plain register rising one cycle after start.
              r_state       <= S_ISSUE;
              r_issued      <= CNT_W'(1);
              r_issue_lfsr  <= lfsr_step(w_seed);
              o_des_start   <= 1'b1;
              o_des_message <= w_seed;
              o_busy        <= 1'b1;
              o_done        <= 1'b0;
            end
          end else if (i_des_output_valid) begin
            o_err <= 1'b1;
          end
        end
        S_ISSUE, S_DRAIN: begin
          if (r_state == S_ISSUE) begin
            if (r_issued == r_num) begin
              o_des_start <= 1'b0;
              r_state     <= S_DRAIN;
            end else begin
              o_des_message <= r_issue_lfsr;
              r_issue_lfsr  <= lfsr_step(r_issue_lfsr);
              r_issued      <= r_issued + CNT_W'(1);
            end
          end
          if (w_rx_ok) begin
            o_pair_valid      <= 1'b1;
            o_pair_plaintext  <= r_check_lfsr;
            o_pair_ciphertext <= i_des_result;
            r_check_lfsr      <= lfsr_step(r_check_lfsr);
            r_received        <= r_received + CNT_W'(1);
          end else if (i_des_output_valid) begin
            o_err <= 1'b1;
          end
          if (w_rx_last) begin
            r_state     <= S_FINISHED;
            o_des_start <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
